trace_capture: RTL and testbench
================================

// Module: trace_capture
// PURPOSE
//  Hardware receiver for the processor's result stream (OUTVALID/OUTADDR/OUTDATA/DONE).
//  - Timestamps each valid result with a free-running cycle counter.
//  - Buffers results in a FIFO.
//  - Drains them to a host-side reader over a valid/ready handshake.
//  - Signals when the run has ended and every captured result has been read.
// PARAMETERS
//  DEPTH  16  FIFO entries (power of two, >=2)
//  AW     5   result address width
//  DW     32  result data width
//  TSW    16  timestamp/cycle-counter width
// PORTS
//  CK        in   1    clock, all state updates on rising edge
//  RESET_N   in   1    asynchronous, active-low reset
//  OUTVALID  in   1    processor result valid this cycle
//  OUTADDR   in   AW   processor result register address
//  OUTDATA   in   DW   processor result data
//  DONE      in   1    processor finished (level; first high cycle is the event)
//  RD_READY  in   1    reader accepts head entry this cycle
//  RD_VALID  out  1    head entry available
//  RD_TS     out  TSW  head entry timestamp
//  RD_ADDR   out  AW   head entry address
//  RD_DATA   out  DW   head entry data
//  FULL      out  1    FIFO holds DEPTH entries
//  OVERFLOW  out  1    sticky: at least one result dropped
//  FLUSHED   out  1    run ended and FIFO empty
// BEHAVIOUR
//  Reset (RESET_N low, async): all outputs and internal state go to 0; state=RUN.
//  Reset mid-run discards all buffered entries immediately.
//  Cycle counter ts: 0 after reset, +1 every cycle, wraps 2^TSW-1 -> 0.
//  An entry captured on an edge carries the ts value present before that edge.
//  Capture: in RUN with OUTVALID=1, push {ts,OUTADDR,OUTDATA}.
//  - Entry is visible on RD_* one cycle after the capturing edge.
//  RD_*: show-ahead head of FIFO. RD_VALID = !empty.
//  - RD_TS/RD_ADDR/RD_DATA are stable while RD_VALID=1 and RD_READY=0.
//  Pop: RD_VALID & RD_READY at an edge. RD_READY while empty is ignored.
//  Full boundary:
//  - Push when full with a simultaneous pop: both happen; count unchanged, no drop.
//  - Push when full without a pop: entry dropped, OVERFLOW<=1 until reset.
//  Empty boundary: push and pop in the same cycle while empty is not possible,
//   because a push is not visible until the next cycle.
//  Count arithmetic: pointers are log2(DEPTH) bits and wrap; occupancy is a separate
//   counter, 0..DEPTH.
//  FSM (2-bit): RUN -> DRAIN -> FLUSHED.
//  - RUN: captures. DONE=1 -> DRAIN.
//    An OUTVALID in the same cycle as DONE is still captured.
//  - DRAIN: OUTVALID ignored (not counted as drop). FIFO empty -> FLUSHED.
//  - FLUSHED: FLUSHED=1; OUTVALID ignored; held until reset.
//  - DONE when FIFO already empty: RUN->DRAIN, then FLUSHED=1 one cycle later.
//  ts keeps counting in every state.
// CONFIGURATION
//  Macro TRACE_FILTER_EN.
//  Defined: adds ports FILT_MASK in AW and FILT_MATCH in AW.
//  - Capture is additionally qualified by (OUTADDR & FILT_MASK) == (FILT_MATCH & FILT_MASK).
//  - Filtered-out results are not pushed and never set OVERFLOW.
//  Undefined: no filter ports; every OUTVALID in RUN is captured.
// STRUCTURE
//  Package trace_pkg:
//  - state encodings ST_RUN=0, ST_DRAIN=1, ST_FLUSHED=2;
//  - entry width function/localparam EW = TSW+AW+DW;
//  - field offsets for packing and unpacking.
//  Sub-module trace_fifo (DEPTH, EW):
//  - show-ahead FIFO with push, pop, full, empty and occupancy;
//  - async active-low reset.
//  The top level holds ts, the FSM, filter and drop logic, and field unpacking.
// TESTING
//  1 Reset, OUTVALID at ts=3 with addr=05, data=DEADBEEF.
//    -> next cycle RD_VALID=1, RD_TS=0003, RD_ADDR=05, RD_DATA=DEADBEEF.
//  2 Push 17 back-to-back with RD_READY=0.
//    -> FULL=1 after 16; 17th dropped; OVERFLOW=1.
//    Drain: 16 entries, in order, with consecutive ts.
//  3 FIFO full; OUTVALID and RD_READY both high for 4 cycles.
//    -> no drop; OVERFLOW stays 0; occupancy remains 16.
//  4 DONE with OUTVALID in the same cycle, then OUTVALID for 2 more cycles.
//    -> only the DONE-cycle result is captured; after the final pop, FLUSHED=1 next cycle.
//  5 Hold ts through 2^16 cycles.
//    -> capture at wrap shows RD_TS=FFFF, then 0000 for the next cycle.
//  6 RESET_N low mid-run with 5 entries buffered.
//    -> RD_VALID, FULL, OVERFLOW, FLUSHED go to 0 with no clock edge; state RUN.
//    With TRACE_FILTER_EN, FILT_MASK=1F and FILT_MATCH=02: only addr 02 is captured.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and entry layout for the trace capture block.
// Entry packing, MSB to LSB: {ts, addr, data}.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_FLUSHED = 2'd2
  } state_t;

  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned AW_DEF    = 5;
  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned TSW_DEF   = 16;

  function automatic int unsigned entry_width(int unsigned tsw, int unsigned aw,
                                              int unsigned dw);
    return tsw + aw + dw;
  endfunction

  function automatic int unsigned data_lsb();
    return 0;
  endfunction

  function automatic int unsigned addr_lsb(int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned ts_lsb(int unsigned aw, int unsigned dw);
    return aw + dw;
  endfunction

  localparam int unsigned EW = entry_width(TSW_DEF, AW_DEF, DW_DEF);

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO: head entry is presented combinationally on rdata.
module trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned EW    = 53
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [EW-1:0]            wdata,
  output logic [EW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  // Pointers wrap naturally at DEPTH; occupancy is tracked separately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + PW'(1);
      end
      if (do_pop) rptr <= rptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/trace_capture.sv
// Timestamped capture of the processor result stream into a FIFO drained by a host reader.
// Optional address filter enabled by defining TRACE_FILTER_EN.
module trace_capture
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32,
  parameter int unsigned TSW   = 16
) (
  input  logic           CK,
  input  logic           RESET_N,
  input  logic           OUTVALID,
  input  logic [AW-1:0]  OUTADDR,
  input  logic [DW-1:0]  OUTDATA,
  input  logic           DONE,
  input  logic           RD_READY,
`ifdef TRACE_FILTER_EN
  input  logic [AW-1:0]  FILT_MASK,
  input  logic [AW-1:0]  FILT_MATCH,
`endif
  output logic           RD_VALID,
  output logic [TSW-1:0] RD_TS,
  output logic [AW-1:0]  RD_ADDR,
  output logic [DW-1:0]  RD_DATA,
  output logic           FULL,
  output logic           OVERFLOW,
  output logic           FLUSHED
);

  localparam int unsigned ENTRY_W = entry_width(TSW, AW, DW);
  localparam int unsigned D_LSB   = data_lsb();
  localparam int unsigned A_LSB   = addr_lsb(DW);
  localparam int unsigned T_LSB   = ts_lsb(AW, DW);

  state_t                 state;
  state_t                 next_state;
  logic [TSW-1:0]         ts;
  logic                   addr_hit;
  logic                   capture_req;
  logic                   push;
  logic                   pop;
  logic                   drop;
  logic                   full;
  logic                   empty;
  logic [ENTRY_W-1:0]     wdata;
  logic [ENTRY_W-1:0]     rdata;
  logic [$clog2(DEPTH):0] occupancy;

`ifdef TRACE_FILTER_EN
  assign addr_hit = ((OUTADDR & FILT_MASK) == (FILT_MATCH & FILT_MASK));
`else
  assign addr_hit = 1'b1;
`endif

  assign capture_req = (state == ST_RUN) && OUTVALID && addr_hit;
  assign pop         = RD_READY && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push        = capture_req && (!full || pop);
  assign drop        = capture_req && full && !pop;
  assign wdata       = {ts, OUTADDR, OUTDATA};

  trace_fifo #(
    .DEPTH (DEPTH),
    .EW    (ENTRY_W)
  ) u_fifo (
    .clk   (CK),
    .rst_n (RESET_N),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  always_ff @(posedge CK or negedge RESET_N) begin
    if (!RESET_N) begin
      ts       <= '0;
      state    <= ST_RUN;
      OVERFLOW <= 1'b0;
    end else begin
      ts    <= ts + TSW'(1);
      state <= next_state;
      if (drop) OVERFLOW <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_RUN:     if (DONE) next_state = ST_DRAIN;
      ST_DRAIN:   if (empty) next_state = ST_FLUSHED;
      ST_FLUSHED: next_state = ST_FLUSHED;
      default:    next_state = ST_RUN;
    endcase
  end

  assign RD_VALID = !empty;
  assign FULL     = full;
  assign FLUSHED  = (state == ST_FLUSHED);
  assign RD_DATA  = rdata[D_LSB +: DW];
  assign RD_ADDR  = rdata[A_LSB +: AW];
  assign RD_TS    = rdata[T_LSB +: TSW];

  occupancy_in_range: assert property (@(posedge CK) disable iff (!RESET_N)
    occupancy <= ($clog2(DEPTH)+1)'(DEPTH));

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture with a scoreboard queue of expected FIFO entries.
module tb_trace_capture;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned TSW   = 16;
  localparam int unsigned EW    = TSW + AW + DW;

  logic           CK;
  logic           RESET_N;
  logic           OUTVALID;
  logic [AW-1:0]  OUTADDR;
  logic [DW-1:0]  OUTDATA;
  logic           DONE;
  logic           RD_READY;
  logic           RD_VALID;
  logic [TSW-1:0] RD_TS;
  logic [AW-1:0]  RD_ADDR;
  logic [DW-1:0]  RD_DATA;
  logic           FULL;
  logic           OVERFLOW;
  logic           FLUSHED;
`ifdef TRACE_FILTER_EN
  logic [AW-1:0]  FILT_MASK;
  logic [AW-1:0]  FILT_MATCH;
`endif

  trace_capture #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW),
    .TSW   (TSW)
  ) dut (
    .CK         (CK),
    .RESET_N    (RESET_N),
    .OUTVALID   (OUTVALID),
    .OUTADDR    (OUTADDR),
    .OUTDATA    (OUTDATA),
    .DONE       (DONE),
    .RD_READY   (RD_READY),
`ifdef TRACE_FILTER_EN
    .FILT_MASK  (FILT_MASK),
    .FILT_MATCH (FILT_MATCH),
`endif
    .RD_VALID   (RD_VALID),
    .RD_TS      (RD_TS),
    .RD_ADDR    (RD_ADDR),
    .RD_DATA    (RD_DATA),
    .FULL       (FULL),
    .OVERFLOW   (OVERFLOW),
    .FLUSHED    (FLUSHED)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Reference cycle counter: value seen at a falling edge is the ts the next rising edge captures.
  logic [TSW-1:0] tb_ts;
  always @(posedge CK or negedge RESET_N) begin
    if (!RESET_N) tb_ts <= '0;
    else          tb_ts <= tb_ts + 16'd1;
  end

  int unsigned     total;
  int unsigned     passed;
  logic [EW-1:0]   sb[$];
  int              m_count;
  int              m_state;
  logic            m_ovf;
  logic [AW-1:0]   m_mask;
  logic [AW-1:0]   m_match;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    sb.delete();
    m_count = 0;
    m_state = 0;
    m_ovf   = 1'b0;
  endtask

  // Called at a falling edge: check outputs, drive inputs, advance the model, wait one cycle.
  task automatic step(input string tag, input logic ov, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data, input logic done, input logic rdy);
    logic          pop;
    logic          hit;
    int            old_count;
    logic [EW-1:0] head;
    chk({tag, "_valid"},    64'(RD_VALID), 64'(m_count > 0));
    chk({tag, "_full"},     64'(FULL),     64'(m_count == DEPTH));
    chk({tag, "_overflow"}, 64'(OVERFLOW), 64'(m_ovf));
    chk({tag, "_flushed"},  64'(FLUSHED),  64'(m_state == 2));
    if (m_count > 0) begin
      head = sb[0];
      chk({tag, "_ts"},   64'(RD_TS),   64'(head[EW-1 -: TSW]));
      chk({tag, "_addr"}, 64'(RD_ADDR), 64'(head[DW +: AW]));
      chk({tag, "_data"}, 64'(RD_DATA), 64'(head[DW-1:0]));
    end
    pop = rdy && (m_count > 0);
    if (pop) void'(sb.pop_front());
    OUTVALID = ov;
    OUTADDR  = addr;
    OUTDATA  = data;
    DONE     = done;
    RD_READY = rdy;
    hit = ((addr & m_mask) == (m_match & m_mask));
    old_count = m_count;
    if (pop) m_count--;
    if (m_state == 0 && ov && hit) begin
      if (old_count < DEPTH || pop) begin
        sb.push_back({tb_ts, addr, data});
        m_count++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (m_state == 0 && done) m_state = 1;
    else if (m_state == 1 && old_count == 0) m_state = 2;
    @(negedge CK);
  endtask

  task automatic idle(input string tag, input int unsigned n, input logic rdy);
    for (int unsigned k = 0; k < n; k++) step(tag, 1'b0, '0, '0, 1'b0, rdy);
  endtask

  // Reset asserted between clock edges and checked before any edge arrives.
  task automatic do_reset(input string tag);
    @(negedge CK);
    #2;
    RESET_N  = 1'b0;
    OUTVALID = 1'b0;
    DONE     = 1'b0;
    RD_READY = 1'b0;
    #1;
    chk({tag, "_rst_valid"},    64'(RD_VALID), 64'd0);
    chk({tag, "_rst_full"},     64'(FULL),     64'd0);
    chk({tag, "_rst_overflow"}, 64'(OVERFLOW), 64'd0);
    chk({tag, "_rst_flushed"},  64'(FLUSHED),  64'd0);
    chk({tag, "_rst_ts"},       64'(RD_TS),    64'd0);
    chk({tag, "_rst_data"},     64'(RD_DATA),  64'd0);
    @(negedge CK);
    @(negedge CK);
    RESET_N = 1'b1;
    model_reset();
  endtask

  initial begin
    int unsigned guard;
    total    = 0;
    passed   = 0;
    RESET_N  = 1'b0;
    OUTVALID = 1'b0;
    OUTADDR  = '0;
    OUTDATA  = '0;
    DONE     = 1'b0;
    RD_READY = 1'b0;
    m_mask   = '0;
    m_match  = '0;
`ifdef TRACE_FILTER_EN
    FILT_MASK  = '0;
    FILT_MATCH = '0;
`endif
    model_reset();

    // 1: single capture at ts=3
    do_reset("t1");
    guard = 0;
    while (tb_ts != 16'd3 && guard < 10) begin
      idle("t1_wait", 1, 1'b0);
      guard++;
    end
    step("t1_cap", 1'b1, 5'h05, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("t1_ts_const",   64'(RD_TS),   64'h0003);
    chk("t1_addr_const", 64'(RD_ADDR), 64'h05);
    chk("t1_data_const", 64'(RD_DATA), 64'hDEADBEEF);
    idle("t1_hold", 2, 1'b0);
    idle("t1_pop", 2, 1'b1);

    // 2: 17 pushes into a 16-deep FIFO, then drain
    do_reset("t2");
    for (int i = 0; i < 17; i++)
      step("t2_push", 1'b1, 5'(i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
    chk("t2_full_const",     64'(FULL),     64'd1);
    chk("t2_overflow_const", 64'(OVERFLOW), 64'd1);
    idle("t2_drain", 17, 1'b1);

    // 3: full with simultaneous push and pop
    do_reset("t3");
    for (int i = 0; i < 16; i++)
      step("t3_fill", 1'b1, 5'(i), 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step("t3_both", 1'b1, 5'(20 + i), 32'hC000_0000 + 32'(i), 1'b0, 1'b1);
    chk("t3_full_const",     64'(FULL),     64'd1);
    chk("t3_overflow_const", 64'(OVERFLOW), 64'd0);
    idle("t3_drain", 17, 1'b1);

    // 4: DONE with OUTVALID, later OUTVALIDs ignored, then flush
    do_reset("t4");
    step("t4_done", 1'b1, 5'h03, 32'h1234_5678, 1'b1, 1'b0);
    step("t4_late", 1'b1, 5'h04, 32'h1111_1111, 1'b0, 1'b0);
    step("t4_late", 1'b1, 5'h06, 32'h2222_2222, 1'b0, 1'b0);
    step("t4_pop", 1'b0, '0, '0, 1'b0, 1'b1);
    chk("t4_flushed_pre", 64'(FLUSHED), 64'd0);
    idle("t4_flush", 3, 1'b1);
    chk("t4_flushed_const", 64'(FLUSHED), 64'd1);

    // 5: timestamp wrap
    do_reset("t5");
    guard = 0;
    while (tb_ts != 16'hFFFF && guard < 70000) begin
      @(negedge CK);
      guard++;
    end
    chk("t5_reach_ffff", 64'(tb_ts), 64'hFFFF);
    step("t5_cap_ffff", 1'b1, 5'h0A, 32'h0000_FFFF, 1'b0, 1'b0);
    step("t5_cap_0000", 1'b1, 5'h0B, 32'h0000_0000, 1'b0, 1'b0);
    chk("t5_ts_ffff", 64'(RD_TS), 64'hFFFF);
    idle("t5_pop", 1, 1'b1);
    chk("t5_ts_0000", 64'(RD_TS), 64'h0000);
    idle("t5_drain", 2, 1'b1);

    // 6: async reset with 5 entries buffered, then capture resumes in RUN
    do_reset("t6");
    for (int i = 0; i < 5; i++)
      step("t6_fill", 1'b1, 5'(i), 32'hE000_0000 + 32'(i), 1'b0, 1'b0);
    chk("t6_valid_pre", 64'(RD_VALID), 64'd1);
    do_reset("t6");
    step("t6_after", 1'b1, 5'h07, 32'h7777_7777, 1'b0, 1'b0);
    idle("t6_drain", 2, 1'b1);

`ifdef TRACE_FILTER_EN
    do_reset("t7");
    FILT_MASK  = 5'h1F;
    FILT_MATCH = 5'h02;
    m_mask     = 5'h1F;
    m_match    = 5'h02;
    step("t7_a1", 1'b1, 5'h01, 32'h0000_0001, 1'b0, 1'b0);
    step("t7_a2", 1'b1, 5'h02, 32'h0000_0002, 1'b0, 1'b0);
    step("t7_a3", 1'b1, 5'h03, 32'h0000_0003, 1'b0, 1'b0);
    step("t7_a2b", 1'b1, 5'h02, 32'h0000_0004, 1'b0, 1'b0);
    idle("t7_drain", 3, 1'b1);
`endif

    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
